// File: rtl/sprite_eval.sv
// rtl/sprite_eval.sv - per-scanline sprite evaluation into secondary OAM
// Clears secondary OAM, then copies up to MAX_SPRITES in-range primary OAM sprites.
module sprite_eval #(
    parameter int OAM_ENTRIES = 64,
    parameter int MAX_SPRITES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixel_en,
    input  logic       eval_start,
    input  logic [8:0] scanline,
    input  logic       sprite_16,
    output logic [7:0] oam_addr,
    input  logic [7:0] oam_din,
    output logic [4:0] soam_addr,
    output logic [7:0] soam_dout,
    output logic       soam_we,
    output logic [3:0] sprite_count,
    output logic       sprite0_in_range,
    output logic       overflow,
    output logic       eval_done
);

    localparam int            NW      = $clog2(OAM_ENTRIES);
    localparam logic [NW-1:0] LAST_N  = NW'(OAM_ENTRIES - 1);
    localparam logic [3:0]    MAX_CNT = 4'(MAX_SPRITES);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RD_Y,
        CHK_Y,
        RD_B,
        WR_B,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [NW-1:0] n, n_n;
    logic [1:0]    b, b_n;
    logic [3:0]    count, count_n;
    logic [4:0]    clr, clr_n;
    logic          s0, s0_n;
    logic          ovf, ovf_n;
    logic [7:0]    oam_addr_n;

    // Range test is unsigned and one-sided: a Y above the scanline never wraps in.
    logic [8:0] y_ext;
    logic [8:0] diff;
    logic [8:0] height;
    logic       in_range;

    assign y_ext    = {1'b0, oam_din};
    assign diff     = scanline - y_ext;
    assign height   = sprite_16 ? 9'd16 : 9'd8;
    assign in_range = (scanline >= y_ext) && (diff < height);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            n        <= '0;
            b        <= '0;
            count    <= '0;
            clr      <= '0;
            s0       <= 1'b0;
            ovf      <= 1'b0;
            oam_addr <= '0;
        end else begin
            state    <= state_n;
            n        <= n_n;
            b        <= b_n;
            count    <= count_n;
            clr      <= clr_n;
            s0       <= s0_n;
            ovf      <= ovf_n;
            oam_addr <= oam_addr_n;
        end
    end

    always_comb begin
        state_n    = state;
        n_n        = n;
        b_n        = b;
        count_n    = count;
        clr_n      = clr;
        s0_n       = s0;
        ovf_n      = ovf;
        oam_addr_n = oam_addr;
        soam_we    = 1'b0;
        soam_addr  = '0;
        soam_dout  = '0;

        case (state)
            IDLE, DONE: begin
                // Acceptance does not wait for a dot tick.
                if (eval_start) begin
                    state_n = CLEAR;
                    n_n     = '0;
                    b_n     = '0;
                    count_n = '0;
                    clr_n   = '0;
                    s0_n    = 1'b0;
                    ovf_n   = 1'b0;
                end
            end

            CLEAR: begin
                soam_addr = clr;
                soam_dout = 8'hFF;
                soam_we   = pixel_en;
                if (pixel_en) begin
                    clr_n = clr + 5'd1;
                    if (clr == 5'd31) begin
                        state_n = RD_Y;
                    end
                end
            end

            RD_Y: begin
                if (pixel_en) begin
                    oam_addr_n = 8'({n, 2'b00});
                    state_n    = CHK_Y;
                end
            end

            CHK_Y: begin
                soam_addr = {count[2:0], 2'b00};
                soam_dout = oam_din;
                if (pixel_en) begin
                    if (in_range) begin
                        if (count < MAX_CNT) begin
                            soam_we = 1'b1;
                            b_n     = 2'd1;
                            state_n = RD_B;
                            if (n == '0) begin
                                s0_n = 1'b1;
                            end
                        end else begin
                            ovf_n   = 1'b1;
                            state_n = DONE;
                        end
                    end else if (n == LAST_N) begin
                        state_n = DONE;
                    end else begin
                        n_n     = n + NW'(1);
                        state_n = RD_Y;
                    end
                end
            end

            RD_B: begin
                if (pixel_en) begin
                    oam_addr_n = 8'({n, b});
                    state_n    = WR_B;
                end
            end

            WR_B: begin
                soam_addr = {count[2:0], b};
                soam_dout = oam_din;
                if (pixel_en) begin
                    soam_we = 1'b1;
                    if (b == 2'd3) begin
                        count_n = count + 4'd1;
                        if (n == LAST_N) begin
                            state_n = DONE;
                        end else begin
                            n_n     = n + NW'(1);
                            state_n = RD_Y;
                        end
                    end else begin
                        b_n     = b + 2'd1;
                        state_n = RD_B;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign sprite_count     = count;
    assign sprite0_in_range = s0;
    assign overflow         = ovf;
    assign eval_done        = (state == DONE);

endmodule

// File: tb/tb_sprite_eval.sv
// tb/tb_sprite_eval.sv - scoreboard bench for sprite_eval
// Reference model walks the OAM list directly and queues expected writes and results.
module tb_sprite_eval;

    logic       clk;
    logic       rst;
    logic       pixel_en;
    logic       eval_start;
    logic [8:0] scanline;
    logic       sprite_16;
    logic [7:0] oam_addr;
    logic [7:0] oam_din;
    logic [4:0] soam_addr;
    logic [7:0] soam_dout;
    logic       soam_we;
    logic [3:0] sprite_count;
    logic       sprite0_in_range;
    logic       overflow;
    logic       eval_done;

    sprite_eval dut (
        .clk              (clk),
        .rst              (rst),
        .pixel_en         (pixel_en),
        .eval_start       (eval_start),
        .scanline         (scanline),
        .sprite_16        (sprite_16),
        .oam_addr         (oam_addr),
        .oam_din          (oam_din),
        .soam_addr        (soam_addr),
        .soam_dout        (soam_dout),
        .soam_we          (soam_we),
        .sprite_count     (sprite_count),
        .sprite0_in_range (sprite0_in_range),
        .overflow         (overflow),
        .eval_done        (eval_done)
    );

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        int count;
        int s0;
        int ovf;
        int steps;
        int tog;
    } res_t;

    logic [7:0] oam [256];
    wr_t        wq[$];
    res_t       rq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         step_cnt = 0;
    int         clk_cnt = 0;
    int         pe_mode = 0;
    logic       start_real = 1'b0;
    logic       done_d = 1'b0;

    // Primary OAM is a synchronous RAM whose address register is oam_addr.
    assign oam_din = oam[oam_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            step_cnt <= 0;
            clk_cnt  <= 0;
        end else if (eval_start && start_real) begin
            step_cnt <= 0;
            clk_cnt  <= 0;
        end else begin
            clk_cnt <= clk_cnt + 1;
            if (pixel_en) step_cnt <= step_cnt + 1;
        end
    end

    always @(negedge clk) begin
        wr_t  w;
        res_t r;
        if (rst) begin
            done_d <= 1'b0;
        end else begin
            if (soam_we) begin
                if (!pixel_en) chk("we_without_step", 1, 0);
                if (wq.size() == 0) begin
                    chk("unexpected_write", int'(soam_addr), -1);
                end else begin
                    w = wq.pop_front();
                    chk("soam_addr", int'(soam_addr), int'(w.addr));
                    chk("soam_dout", int'(soam_dout), int'(w.data));
                end
            end
            if (eval_done && !done_d) begin
                if (rq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    r = rq.pop_front();
                    chk("sprite_count", int'(sprite_count), r.count);
                    chk("sprite0_in_range", int'(sprite0_in_range), r.s0);
                    chk("overflow", int'(overflow), r.ovf);
                    chk("done_steps", step_cnt, r.steps);
                    if (r.tog != 0) chk("toggle_clks", clk_cnt, 2 * r.steps);
                end
            end
            done_d <= eval_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        eval_start = 1'b0;
        case (pe_mode)
            0:       pixel_en = 1'b1;
            1:       pixel_en = ~pixel_en;
            default: pixel_en = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic push_expect();
        int found = 0;
        int scanned = 0;
        int s0 = 0;
        int ovf = 0;
        int h = sprite_16 ? 16 : 8;
        for (int a = 0; a < 32; a++) wq.push_back('{5'(a), 8'hFF});
        for (int e = 0; e < 64; e++) begin
            int d;
            d = int'(scanline) - int'(oam[4 * e]);
            scanned++;
            if (d >= 0 && d < h) begin
                if (found == 8) begin
                    ovf = 1;
                    break;
                end
                if (e == 0) s0 = 1;
                for (int k = 0; k < 4; k++) wq.push_back('{5'(found * 4 + k), oam[4 * e + k]});
                found++;
            end
        end
        rq.push_back('{found, s0, ovf, 32 + 2 * scanned + 6 * found, (pe_mode == 1) ? 1 : 0});
    endtask

    task automatic run_eval(input int mid, input int abort);
        int seen33 = 0;
        int mid_done = 0;
        int got = 0;
        push_expect();
        eval_start = 1'b1;
        start_real = 1'b1;
        pixel_en   = 1'b1;
        tick();
        start_real = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (eval_done) begin
                got = 1;
                break;
            end
            if (seen33 == 0 && step_cnt == 33) begin
                chk("first_oam_addr", int'(oam_addr), 0);
                seen33 = 1;
            end
            if (mid != 0 && mid_done == 0 && step_cnt == 50) begin
                eval_start = 1'b1;
                mid_done = 1;
            end
            if (abort != 0 && step_cnt > 32 && soam_we && soam_addr[1:0] == 2'd2) begin
                rst = 1'b1;
                tick();
                chk("abort_count", int'(sprite_count), 0);
                chk("abort_s0", int'(sprite0_in_range), 0);
                chk("abort_ovf", int'(overflow), 0);
                chk("abort_done", int'(eval_done), 0);
                chk("abort_oam_addr", int'(oam_addr), 0);
                chk("abort_we", int'(soam_we), 0);
                wq.delete();
                rq.delete();
                rst = 1'b0;
                tick();
                return;
            end
            tick();
        end
        if (got == 0) begin
            chk("done_timeout", 0, 1);
            wq.delete();
            rq.delete();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            tick();
        end else begin
            tick();
            tick();
            chk("writes_pending", wq.size(), 0);
            chk("results_pending", rq.size(), 0);
        end
    endtask

    task automatic fill_ff();
        for (int i = 0; i < 256; i++) oam[i] = 8'hFF;
    endtask

    task automatic fill_random();
        for (int e = 0; e < 64; e++) begin
            if ($urandom_range(0, 2) == 0)
                oam[4 * e] = 8'(int'(scanline) - int'($urandom_range(0, 17)));
            else
                oam[4 * e] = 8'($urandom);
            for (int k = 1; k < 4; k++) oam[4 * e + k] = 8'($urandom);
        end
    endtask

    task automatic load_sprite0();
        fill_ff();
        oam[0] = 8'h0A;
        oam[1] = 8'h21;
        oam[2] = 8'h43;
        oam[3] = 8'h80;
        scanline  = 9'd12;
        sprite_16 = 1'b0;
    endtask

    initial begin
        int edge_sl[6]  = '{115, 116, 99, 107, 108, 5};
        int edge_s16[6] = '{1, 1, 1, 0, 0, 0};
        int edge_y[6]   = '{100, 100, 100, 100, 100, 250};

        rst        = 1'b1;
        eval_start = 1'b0;
        pixel_en   = 1'b1;
        scanline   = '0;
        sprite_16  = 1'b0;
        fill_ff();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_we", int'(soam_we), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("reset_oam_addr", int'(oam_addr), 0);
        chk("reset_count", int'(sprite_count), 0);
        chk("reset_s0", int'(sprite0_in_range), 0);
        chk("reset_ovf", int'(overflow), 0);
        chk("reset_done", int'(eval_done), 0);
        chk("reset_soam_addr", int'(soam_addr), 0);
        chk("reset_soam_dout", int'(soam_dout), 0);
        tick();

        // Nine sprites on the same line: eight copied, then overflow.
        for (int i = 0; i < 256; i++) oam[i] = 8'($urandom);
        for (int e = 0; e < 9; e++) oam[4 * e] = 8'd20;
        for (int e = 9; e < 64; e++) oam[4 * e] = 8'hFF;
        scanline  = 9'd25;
        sprite_16 = 1'b0;
        run_eval(0, 0);

        load_sprite0();
        run_eval(0, 0);

        for (int t = 0; t < 6; t++) begin
            fill_ff();
            oam[20]   = 8'(edge_y[t]);
            oam[21]   = 8'(t);
            scanline  = 9'(edge_sl[t]);
            sprite_16 = 1'(edge_s16[t]);
            run_eval(0, 0);
        end

        pe_mode = 1;
        load_sprite0();
        run_eval(0, 0);
        pe_mode = 2;
        scanline = 9'($urandom_range(0, 261));
        fill_random();
        run_eval(0, 0);

        pe_mode = 0;
        scanline = 9'($urandom_range(0, 239));
        fill_random();
        run_eval(1, 0);

        load_sprite0();
        run_eval(0, 1);
        run_eval(0, 0);

        for (int r = 0; r < 16; r++) begin
            pe_mode   = int'($urandom_range(0, 2));
            scanline  = 9'($urandom_range(0, 261));
            sprite_16 = 1'($urandom_range(0, 1));
            fill_random();
            run_eval(int'($urandom_range(0, 3) == 0), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sprite_eval.md
Name: sprite_eval

Overview:
- Per-scanline sprite evaluation stage of the PPU, directly upstream of the sprite fetch path that loads sprite_buffer instances.
- Clears the 32-byte secondary OAM, then scans the 64 primary OAM entries and copies up to 8 in-range sprites (Y, tile, attr, X) into secondary OAM.
- Reports sprite count, a sprite-0 flag and an overflow flag. The fetch sequencer later reads secondary OAM to drive each buffer's sprite_x_in, sprite_attr_in, pattern loads and valid_sprite.

Parameters:
- OAM_ENTRIES, 64, number of primary OAM sprites scanned.
- MAX_SPRITES, 8, secondary OAM capacity in sprites (4 bytes each).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- pixel_en  input  1  PPU dot tick. All state advances only on clk edges where pixel_en=1 (a "step").
- eval_start  input  1  one-clk pulse starting evaluation. Sampled on any clk while IDLE or DONE.
- scanline  input  9  line number compared against sprite Y
- sprite_16  input  1  0 = 8x8 sprites, 1 = 8x16 sprites
- oam_addr  output  8  primary OAM read address (registered)
- oam_din  input  8  primary OAM read data, valid the step after oam_addr changes (synchronous RAM)
- soam_addr  output  5  secondary OAM write address
- soam_dout  output  8  secondary OAM write data
- soam_we  output  1  secondary OAM write enable, high only on step cycles
- sprite_count  output  4  sprites copied this line, 0..8
- sprite0_in_range  output  1  OAM entry 0 was copied this line
- overflow  output  1  more than MAX_SPRITES sprites in range
- eval_done  output  1  evaluation complete, held until next eval_start

Behaviour:
- Reset: all outputs 0, state IDLE.
  - rst mid-operation aborts to IDLE the same cycle.
  - Partially written secondary OAM is left as is.
- States: IDLE, CLEAR, RD_Y, CHK_Y, RD_B, WR_B, DONE.
- IDLE/DONE + eval_start:
  - Clear sprite_count, sprite0_in_range, overflow and eval_done.
  - Set n=0 and go to CLEAR. No pixel_en is needed for this transition.
  - eval_start in any other state is ignored.
- CLEAR: 32 steps. soam_we=1, soam_addr=0..31, soam_dout=8'hFF. After address 31, go to RD_Y.
- RD_Y (1 step): oam_addr={n,2'b00}, go to CHK_Y.
- CHK_Y (1 step): y=oam_din, diff=scanline-{1'b0,y} (9-bit). In range iff scanline>={0,y} and diff<(sprite_16?16:8). No wrap-around.
  - In range and count<8: write y to soam_addr={count,2'b00}, set b=1, go to RD_B. If n==0, set sprite0_in_range.
  - In range and count==8: overflow=1, go to DONE immediately.
  - Not in range: if n==63 go to DONE, else n++ and go to RD_Y.
- RD_B (1 step): oam_addr={n,b}, go to WR_B.
- WR_B (1 step): write oam_din unmodified to soam_addr={count,b}.
  - If b==3: count++; then if n==63 go to DONE, else n++ and go to RD_Y.
  - Else b++ and go to RD_B.
- DONE: eval_done=1, soam_we=0. Outputs stay frozen until eval_start or rst.
- Timing from acceptance: eval_done rises after 32 + 2*(sprites scanned) + 6*(sprites copied) steps. The worst case without overflow is 32+128+48=208, which fits inside dots 1..256.
- pixel_en=0: no state, address or counter changes, and soam_we=0.
- sprite_count never exceeds 8. Secondary OAM slots beyond count keep FF from CLEAR.
- Overflow uses the straightforward count rule (no hardware diagonal-scan bug emulation).

Test Plan:
- rst held 3 clks, then released -> all outputs 0, soam_we never asserts, eval_done=0.
- eval_start with pixel_en=1 every clk -> 32 consecutive writes of FF to soam_addr 0..31, then first oam_addr=0.
- OAM[0]={0A,21,43,80}, all other Y=FF, scanline=12, sprite_16=0:
  - soam[0..3]=0A,21,43,80.
  - sprite_count=1, sprite0_in_range=1, overflow=0.
  - eval_done after exactly 166 steps.
- OAM entries 0..8 Y=20, scanline=25 -> soam holds entries 0..7, sprite_count=8, overflow=1. DONE is reached at entry 8's CHK_Y (32+9*2+8*6=98 steps).
- Range edges:
  - Y=100, sprite_16=1: scanline 115 is in, 116 is out, 99 is out.
  - sprite_16=0: scanline 107 is in, 108 is out.
  - Y=250, scanline=5: out.
- Robustness:
  - pixel_en toggled 1/0 -> identical results, with completion taking twice as many clks.
  - eval_start mid-scan -> ignored.
  - rst during WR_B -> IDLE next cycle, outputs 0.
  - A new eval_start then completes normally.
